// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial link serializer/deserializer pair.
package serdes_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_e;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;
endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / parallel-out bundle: serial side plus word handshake and status pulses.
interface serial_deserializer_if
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             bit_valid;
  logic             bit_in;
  logic             frame_start;
  logic             msb_first;
  logic             data_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;
  logic             sync_err;

  modport master (
    output bit_valid, bit_in, frame_start, msb_first, data_ready,
    input  data_out, data_valid, busy, overrun, sync_err
  );

  modport slave (
    input  bit_valid, bit_in, frame_start, msb_first, data_ready,
    output data_out, data_valid, busy, overrun, sync_err
  );
endinterface

// File: rtl/deser_shift_reg.sv
// WIDTH-bit shift register; o_next exposes the post-edge value so the completing
// bit can be captured into the output word on the same edge.
module deser_shift_reg
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_base;

  // Clear and shift may coincide: the first bit of a frame lands in a zeroed register.
  always_comb begin
    w_base = i_clr ? '0 : r_q;
    o_next = w_base;
    if (i_en)
      o_next = (i_mode == MSB_FIRST) ? {w_base[WIDTH-2:0], i_bit}
                                     : {i_bit, w_base[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) r_q <= '0;
    else       r_q <= o_next;
  end
endmodule

// File: rtl/serial_deserializer.sv
// Frame FSM, bit counter and registered valid/ready output stage around deser_shift_reg.
module serial_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  serial_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_COLLECT = COLLECT;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_mode;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_sync_err;

  logic             w_collect;
  logic             w_start;
  logic             w_shift;
  logic             w_done;
  logic             w_mode;
  logic [WIDTH-1:0] w_sr_next;

  assign w_collect = (r_state == ST_COLLECT);
  assign w_start   = bus.bit_valid & bus.frame_start;
  assign w_shift   = bus.bit_valid & (w_collect | bus.frame_start);
  // A frame_start bit always opens a new frame, so it can never complete one.
  assign w_done    = bus.bit_valid & ~bus.frame_start & w_collect &
                     (r_count == CNT_W'(WIDTH - 1));
  assign w_mode    = w_start ? bus.msb_first : r_mode;

  deser_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_start),
    .i_en   (w_shift),
    .i_mode (w_mode),
    .i_bit  (bus.bit_in),
    .o_next (w_sr_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_mode     <= MSB_FIRST;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_start & w_collect;
      r_overrun  <= w_done & r_valid & ~bus.data_ready;
      if (w_start) begin
        r_state <= ST_COLLECT;
        r_count <= CNT_W'(1);
        r_mode  <= bus.msb_first;
      end else if (w_done) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else if (w_shift) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_done) begin
        r_data  <= w_sr_next;
        r_valid <= 1'b1;
      end else if (r_valid & bus.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = w_collect;
  assign bus.overrun    = r_overrun;
  assign bus.sync_err   = r_sync_err;
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed and randomized checks of serial_deserializer against a bit-queue frame model.
module tb_serial_deserializer;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serial_deserializer_if #(.WIDTH(W)) bus ();

  serial_deserializer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Frame model: bits collected in arrival order, word assembled on the W-th bit.
  bit         q_bits[$];
  logic       m_in_frame = 1'b0;
  logic       m_mode     = 1'b1;
  logic [W-1:0] m_dout   = '0;
  logic       m_dv       = 1'b0;
  logic       m_ovr      = 1'b0;
  logic       m_sync     = 1'b0;

  function automatic logic [W-1:0] assemble(input logic msb);
    logic [W-1:0] word;
    word = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) word[W-1-i] = q_bits[i];
      else     word[i]     = q_bits[i];
    end
    return word;
  endfunction

  task automatic step(input logic rst, input logic bv, input logic bi, input logic fs,
                      input logic msb, input logic rdy);
    logic done, ovr, syn;
    reset = rst;
    bus.bit_valid = bv;
    bus.bit_in = bi;
    bus.frame_start = fs;
    bus.msb_first = msb;
    bus.data_ready = rdy;
    @(posedge clock);
    done = 1'b0; ovr = 1'b0; syn = 1'b0;
    if (rst) begin
      q_bits.delete();
      m_in_frame = 1'b0; m_dout = '0; m_dv = 1'b0;
    end else begin
      if (bv && fs) begin
        syn = m_in_frame;
        q_bits.delete();
        q_bits.push_back(bi);
        m_mode = msb;
        m_in_frame = 1'b1;
      end else if (bv && m_in_frame) begin
        q_bits.push_back(bi);
        done = (q_bits.size() == W);
      end
      if (done) begin
        ovr = m_dv && !rdy;
        m_dout = assemble(m_mode);
        m_dv = 1'b1;
        m_in_frame = 1'b0;
        q_bits.delete();
      end else if (m_dv && rdy) begin
        m_dv = 1'b0;
      end
    end
    m_ovr = ovr;
    m_sync = syn;
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy);
  endtask

  function automatic logic frame_bit(input logic [W-1:0] word, input logic msb, input int i);
    return msb ? word[W-1-i] : word[i];
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.sync_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got dout=%h dv=%b busy=%b ovr=%b sync=%b, want all 0",
               bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.sync_err);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, bits[7-i], (i == 0), 1'b1, 1'b0);
      if (i < 7) begin
        n_vec++;
        if (bus.busy !== 1'b1 || bus.data_valid !== 1'b0) begin
          n_err++;
          $display("FAIL msb_busy bit%0d: got busy=%b dv=%b, want busy=1 dv=0",
                   i, bus.busy, bus.data_valid);
        end
      end
    end
    n_vec++;
    if (bus.data_out !== 8'hB2 || bus.data_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL msb_word: got dout=%h dv=%b busy=%b, want B2 1 0",
               bus.data_out, bus.data_valid, bus.busy);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, bits[7-i], (i == 0), 1'b0, 1'b0);
    n_vec++;
    if (bus.data_out !== 8'h4D || bus.data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL lsb_word: got dout=%h dv=%b, want 4D 1", bus.data_out, bus.data_valid);
    end
    idle(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, bits[7-i], (i == 0), 1'b0, 1'b0);
      if (i < 7) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
          n_vec++;
          if (bus.busy !== 1'b1 || bus.data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gap_hold bit%0d: got busy=%b dv=%b, want 1 0",
                     i, bus.busy, bus.data_valid);
          end
        end
      end
    end
    n_vec++;
    if (bus.data_out !== 8'h4D || bus.data_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_word: got dout=%h dv=%b busy=%b, want 4D 1 0",
               bus.data_out, bus.data_valid, bus.busy);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    int n_ovr;
    words[0] = 8'hA5; words[1] = 8'h3C;
    for (int pass = 0; pass < 2; pass++) begin
      n_ovr = 0;
      for (int f = 0; f < 2; f++)
        for (int i = 0; i < W; i++) begin
          step(1'b0, 1'b1, frame_bit(words[f], 1'b1, i), (i == 0), 1'b1,
               (pass == 1 && f == 1 && i == W-1));
          if (bus.overrun === 1'b1) n_ovr++;
        end
      idle(1, 1'b0);
      if (bus.overrun === 1'b1) n_ovr++;
      n_vec++;
      if (bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_word pass%0d: got dout=%h dv=%b, want 3C 1",
                 pass, bus.data_out, bus.data_valid);
      end
      n_vec++;
      if (n_ovr !== (pass == 0 ? 1 : 0)) begin
        n_err++;
        $display("FAIL b2b_overrun pass%0d: got %0d pulses, want %0d",
                 pass, n_ovr, (pass == 0 ? 1 : 0));
      end
      idle(1, 1'b1);
    end
  endtask

  task automatic test_resync();
    int n_sync;
    n_sync = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i[0], (i == 0), 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, frame_bit(8'hF0, 1'b1, i), (i == 0), 1'b1, 1'b0);
      if (bus.sync_err === 1'b1) n_sync++;
    end
    idle(1, 1'b0);
    if (bus.sync_err === 1'b1) n_sync++;
    n_vec++;
    if (n_sync !== 1) begin
      n_err++;
      $display("FAIL resync_pulse: got %0d pulses, want 1", n_sync);
    end
    n_vec++;
    if (bus.data_out !== 8'hF0 || bus.data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL resync_word: got dout=%h dv=%b, want F0 1", bus.data_out, bus.data_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, (i == 0), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.sync_err} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got dout=%h dv=%b busy=%b, want 0 0 0",
               bus.data_out, bus.data_valid, bus.busy);
    end
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, frame_bit(8'h81, 1'b0, i), (i == 0), 1'b0, 1'b0);
    n_vec++;
    if (bus.data_out !== 8'h81 || bus.data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_word: got dout=%h dv=%b, want 81 1", bus.data_out, bus.data_valid);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.data_out !== 8'h81 || bus.data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ignore: got busy=%b dout=%h dv=%b, want 0 81 1",
               bus.busy, bus.data_out, bus.data_valid);
    end
  endtask

  task automatic test_handshake();
    idle(1, 1'b1);
    n_vec++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h81) begin
      n_err++;
      $display("FAIL consume: got dv=%b dout=%h, want 0 81", bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_random();
    logic bv, fs, rdy, rst;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bv  = ($urandom_range(0, 9) < 7);
      fs  = ($urandom_range(0, 13) == 0);
      rdy = $urandom_range(0, 1);
      step(rst, bv, $urandom_range(0, 1), fs, $urandom_range(0, 1), rdy);
      n_vec++;
      if (bus.data_out !== m_dout || bus.data_valid !== m_dv || bus.busy !== m_in_frame ||
          bus.overrun !== m_ovr || bus.sync_err !== m_sync) begin
        n_err++;
        $display("FAIL random c%0d: got dout=%h dv=%b busy=%b ovr=%b sync=%b, want %h %b %b %b %b",
                 c, bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.sync_err,
                 m_dout, m_dv, m_in_frame, m_ovr, m_sync);
      end
    end
  endtask

  initial begin
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.frame_start = 1'b0;
    bus.msb_first = 1'b1; bus.data_ready = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Serial-in/parallel-out receiver that pairs with the team's parallel-load shift/rotate register.
- Samples one bit per qualified cycle (bit_valid) and assembles WIDTH-bit words, MSB-first or LSB-first.
- Presents each completed word on a registered output with a valid/ready handshake.
- Sits between a serial link (switch/key-driven or a shift-out register) and LED/consumer logic.

Parameters:
WIDTH, 8, word length in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  reset, synchronous, active-high
bit_valid  input  1  qualifies bit_in this cycle
bit_in  input  1  serial data bit
frame_start  input  1  marks bit_in as first bit of a frame (only meaningful with bit_valid)
msb_first  input  1  1: first bit is word MSB; 0: first bit is LSB; latched at frame start
data_ready  input  1  consumer accepts data_out when data_valid=1
data_out  output  WIDTH  last completed word
data_valid  output  1  data_out holds an unconsumed word
busy  output  1  frame in progress (state COLLECT)
overrun  output  1  one-cycle pulse: unconsumed word overwritten
sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame

Behaviour:
- Reset (clock edge with reset=1) overrides all other inputs:
  - data_out=0, data_valid=0, busy=0, overrun=0, sync_err=0.
  - Shift register=0, count=0, state=IDLE.
  - Reset mid-frame discards the partial word.
- States:
  - IDLE: bit_valid=0, or bit_valid=1 with frame_start=0 → ignored, stay IDLE. bit_valid=1 with frame_start=1 → capture bit, latch msb_first into mode_q, count=1, go COLLECT.
  - COLLECT: each bit_valid=1 shifts in one bit and increments count. bit_valid=0 holds all state; there is no timeout.
- Shift rules:
  - mode_q=1: sr <= {sr[WIDTH-2:0], bit_in}.
  - mode_q=0: sr <= {bit_in, sr[WIDTH-1:1]}.
  - After WIDTH bits, sr equals the transmitted word in both modes.
- Completion: the bit_valid cycle on which count reaches WIDTH.
  - Next edge: data_out <= completed word (including the current bit), data_valid <= 1, count <= 0, state <= IDLE.
  - Latency from last bit sampled to data_valid is one cycle.
- Back-to-back frames: a frame_start bit in the cycle immediately after completion is accepted (IDLE is a 0-cycle-dwell state), so there is no dead cycle.
- Resync: bit_valid=1 with frame_start=1 while in COLLECT and count<WIDTH:
  - Partial word is discarded.
  - sync_err=1 for one cycle.
  - The current bit becomes bit 0 of a new frame (count=1, msb_first re-latched).
- Handshake:
  - data_valid falls the edge after data_valid=1 and data_ready=1, unless a word completes on that same cycle.
  - Completion with data_valid=1 and data_ready=1 in the same cycle: new word loaded, data_valid stays 1, no overrun.
  - Completion with data_valid=1 and data_ready=0: data_out overwritten, data_valid stays 1, overrun=1 for one cycle.
  - data_ready is ignored when data_valid=0.
- busy=1 exactly while state=COLLECT.
- overrun and sync_err are registered, independent, and may pulse in different cycles.

Decomposition:
- Shared package serdes_pkg:
  - state enum {IDLE, COLLECT}.
  - Localparam DEFAULT_WIDTH=8.
  - Bit-order constants MSB_FIRST=1'b1, LSB_FIRST=1'b0 (shared with the future serializer).
- Sub-module deser_shift_reg:
  - WIDTH-bit shift register with clear, enable, and direction (mode) inputs.
  - Top level holds the FSM, counter and output handshake register.

Test Plan:
1. Reset, then frame_start+bit_valid with msb_first=1, serial bits 1,0,1,1,0,0,1,0 on consecutive cycles → data_out=8'hB2, data_valid=1 one cycle after 8th bit; busy=1 during bits 1–7 edges.
2. Same bit stream with msb_first=0 → data_out=8'h4D; bit_valid gaps of 3 idle cycles between bits → same result, busy held.
3. Two back-to-back frames 8'hA5 then 8'h3C with data_ready=0 throughout → after 2nd frame data_out=8'h3C, data_valid=1, overrun pulses once. Repeat with data_ready=1 on the 2nd completion cycle → no overrun.
4. Start frame, send 4 bits, assert frame_start with next bit, then 8 bits of 8'hF0 (MSB-first) → sync_err one pulse, data_out=8'hF0 after the new frame's 8th bit.
5. Reset asserted after 5 bits of a frame → all outputs 0. A following frame of 8'h81 decodes correctly. bit_valid without frame_start in IDLE → ignored, busy=0.
6. data_valid=1, raise data_ready one cycle → data_valid=0 next cycle, data_out unchanged.
